mmio_responder: RTL

- Byte-wide memory-mapped I/O responder on the RAM-side bus driven by the memory controller. Decodes accesses whose address bits [17:16] == 2'b11.
- Holds a TX FIFO for console output and an RX FIFO for console input. Exposes a status byte and a halt register.
- Drives io_buffer_full back to the controller so that controller holds I/O stores until there is room.
- Sits beside the main RAM. Top level muxes mem_dout onto the controller's read data whenever io_sel is high.

---
 rtl/mmio_responder_if.sv | 20 ++
 rtl/mmio_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder_if.sv
// Byte-wide memory-controller bus between the controller (master) and the
// MMIO responder (slave), including the I/O-store throttle back to the controller.
interface mmio_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_sel;
  logic        io_buffer_full;

  modport master (
    output mem_a, mem_wr, mem_din,
    input  mem_dout, io_sel, io_buffer_full
  );

  modport slave (
    input  mem_a, mem_wr, mem_din,
    output mem_dout, io_sel, io_buffer_full
  );
endinterface

// File: rtl/mmio_responder.sv
// MMIO console responder: TX/RX byte FIFOs, status and halt registers at 0x3xxxx.
// Define MMIO_LOOPBACK_EN to feed every byte drained from TX straight back into RX.

// Byte FIFO with occupancy counter and sticky overflow flag. A push into a full
// FIFO is accepted when a pop happens in the same cycle.
module mmio_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push_en, pop_en;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign ovf   = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !push_en) ovf_d = 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage holds no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

module mmio_responder #(
  parameter int DEPTH_LOG2  = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_responder_if.slave   bus,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              halt
);
  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [DEPTH_LOG2+1:0] DEPTH_W  = (DEPTH_LOG2+2)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2+1:0] MARGIN_W = (DEPTH_LOG2+2)'(FULL_MARGIN);

  logic       hit, rd_hit, wr_hit;
  logic [2:0] off;

  logic                tx_push, tx_pop, tx_full, tx_empty, tx_ovf;
  logic [DEPTH_LOG2:0] tx_count;
  logic [DEPTH_LOG2+1:0] tx_free;

  logic                rx_push, rx_pop, rx_full, rx_empty, rx_ovf;
  logic [7:0]          rx_push_data, rx_head;
  logic [DEPTH_LOG2:0] rx_count;

  logic [7:0] status;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic       io_sel_q, io_sel_d;
  logic       halt_q, halt_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_a[31:18], bus.mem_a[15:3], rx_full, rx_count};

  assign hit    = (bus.mem_a[17:16] == 2'b11);
  assign off    = bus.mem_a[2:0];
  assign rd_hit = hit && !bus.mem_wr;
  assign wr_hit = hit &&  bus.mem_wr;

  assign tx_push = wr_hit && (off == OFF_DATA);
  assign tx_pop  = tx_valid && tx_ready;
  // Every cycle the data register is read is a pop; the FIFO ignores it when empty.
  assign rx_pop  = rd_hit && (off == OFF_DATA);

`ifdef MMIO_LOOPBACK_EN
  logic unused_rx_in;
  assign unused_rx_in = ^{rx_valid, rx_data};
  assign rx_push      = tx_pop;
  assign rx_push_data = tx_data;
`else
  assign rx_push      = rx_valid;
  assign rx_push_data = rx_data;
`endif

  mmio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tx_push),
    .push_data (bus.mem_din),
    .pop       (tx_pop),
    .head      (tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty),
    .ovf       (tx_ovf)
  );

  mmio_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty),
    .ovf       (rx_ovf)
  );

  assign tx_valid = !tx_empty;
  assign tx_free  = DEPTH_W - {1'b0, tx_count};
  assign bus.io_buffer_full = (tx_free <= MARGIN_W);

  assign status = {4'b0000, rx_ovf, tx_ovf, tx_full, !rx_empty};

  always_comb begin
    mem_dout_d = 8'h00;
    io_sel_d   = rd_hit;
    halt_d     = wr_hit && (off == OFF_CTRL);
    if (rd_hit) begin
      case (off)
        OFF_DATA: mem_dout_d = rx_empty ? 8'h00 : rx_head;
        OFF_CTRL: mem_dout_d = status;
        default:  mem_dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dout_q <= 8'h00;
      io_sel_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      mem_dout_q <= mem_dout_d;
      io_sel_q   <= io_sel_d;
      halt_q     <= halt_d;
    end
  end

  assign bus.mem_dout = mem_dout_q;
  assign bus.io_sel   = io_sel_q;
  assign halt         = halt_q;
endmodule
